// File: rtl/jpeg_pkg.sv
// Shared constants, output FSM encoding and field helpers for the JPEG bit packer.
// Optional feature macro: JPEG_BYTE_STUFF_EN (adds the STUFF state and 0xFF/0x00 stuffing).
package jpeg_pkg;

    localparam int unsigned ACC_W        = 64;
    localparam int unsigned CNT_W        = 7;
    localparam int unsigned MAX_SYM_BITS = 41;
    localparam int unsigned IN_READY_MAX = ACC_W - MAX_SYM_BITS;
    localparam int unsigned DC_CODE_MAX  = 9;
    localparam int unsigned AC_CODE_MAX  = 16;
    localparam int unsigned AMP_MAX      = 8;

    typedef enum logic [1:0] {
        EMIT        = 2'd0,
`ifdef JPEG_BYTE_STUFF_EN
        STUFF       = 2'd1,
`endif
        FLUSH_PAD   = 2'd2,
        FLUSH_DRAIN = 2'd3
    } out_state_t;

    // Limit a requested field length to the field's maximum width.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [7:0] len, input logic [7:0] lim);
        return (len > lim) ? CNT_W'(lim) : CNT_W'(len);
    endfunction

    // Keep only the n least-significant bits of a field, zero-extended to the accumulator width.
    function automatic logic [ACC_W-1:0] field_bits(input logic [15:0] val, input logic [CNT_W-1:0] n);
        return ACC_W'(val) & ((ACC_W'(1) << n) - ACC_W'(1));
    endfunction

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Output byte register with valid/ready on both sides; inserts 0x00 after 0xFF
// when JPEG_BYTE_STUFF_EN is defined.
module jpeg_byte_stuffer
    import jpeg_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready_c,
    output logic       stuff_busy,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready
);

    logic slot_free_c;

    assign slot_free_c = !byte_valid || byte_ready;

`ifdef JPEG_BYTE_STUFF_EN
    // Accept a new byte only when the slot frees and no stuff byte is owed.
    assign s_ready_c = slot_free_c && !stuff_busy;

    // Output register plus the owed-0x00 flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            stuff_busy <= 1'b0;
        end else if (s_valid && s_ready_c) begin
            byte_out   <= s_data;
            byte_valid <= 1'b1;
            stuff_busy <= (s_data == 8'hFF);
        end else if (stuff_busy && slot_free_c) begin
            byte_out   <= 8'h00;
            byte_valid <= 1'b1;
            stuff_busy <= 1'b0;
        end else if (byte_ready) begin
            byte_valid <= 1'b0;
        end
    end
`else
    assign s_ready_c  = slot_free_c;
    assign stuff_busy = 1'b0;

    // Output register; holds while downstream stalls.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
        end else if (s_valid && s_ready_c) begin
            byte_out   <= s_data;
            byte_valid <= 1'b1;
        end else if (byte_ready) begin
            byte_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs Huffman codes and amplitude bits MSB-first into entropy-coded bytes.
// Optional feature macro: JPEG_BYTE_STUFF_EN (0xFF bytes followed by 0x00).
module jpeg_bit_packer
    import jpeg_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        jpeg_out_enable,
    input  logic        jpeg_out_end,
    input  logic [8:0]  jpeg_dc_out,
    input  logic [7:0]  jpeg_dc_out_length,
    input  logic [7:0]  jpeg_dc_code_list,
    input  logic [7:0]  jpeg_dc_code_size,
    input  logic [15:0] huffman_code,
    input  logic [7:0]  huffman_code_length,
    input  logic [7:0]  code_out,
    input  logic [7:0]  code_size_out,
    input  logic        flush,
    output logic        in_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        block_done,
    output logic        flush_done,
    output logic        overflow_err
);

    out_state_t        state, state_n;
    logic [ACC_W-1:0]  acc, acc_n, acc_d, sym;
    logic [CNT_W-1:0]  bit_count, bit_count_n, bc_d, add_len, n;
    logic              dc_armed;
    logic              accept_c, flush_take_c, drain_c;
    logic              in_ready_n, flush_done_n;
    logic              s_ready_c, stuff_busy;

    assign accept_c     = jpeg_out_enable && in_ready;
    assign flush_take_c = flush && (state == EMIT) && !jpeg_out_enable;

    // Output register and optional stuffing.
    jpeg_byte_stuffer u_stuffer (
        .clock      (clock),
        .reset_n    (reset_n),
        .s_valid    (drain_c),
        .s_data     (acc[ACC_W-1 -: 8]),
        .s_ready_c  (s_ready_c),
        .stuff_busy (stuff_busy),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready)
    );

    // Output FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= EMIT;
        else          state <= state_n;
    end

    // Next state, symbol/pad assembly and accumulator update.
    always_comb begin
        state_n      = state;
        flush_done_n = 1'b0;
        sym          = '0;
        add_len      = '0;
        n            = '0;

        drain_c = (bit_count >= CNT_W'(8)) && s_ready_c;
`ifdef JPEG_BYTE_STUFF_EN
        if (state == STUFF) drain_c = 1'b0;
`endif

        unique case (state)
            EMIT: begin
                if (flush_take_c) state_n = FLUSH_PAD;
`ifdef JPEG_BYTE_STUFF_EN
                else if (drain_c && (acc[ACC_W-1 -: 8] == 8'hFF)) state_n = STUFF;
`endif
            end
`ifdef JPEG_BYTE_STUFF_EN
            STUFF: begin
                if (!stuff_busy) state_n = EMIT;
            end
`endif
            FLUSH_PAD: begin
                state_n = FLUSH_DRAIN;
            end
            FLUSH_DRAIN: begin
                if ((bit_count == '0) && !stuff_busy) begin
                    flush_done_n = 1'b1;
                    state_n      = EMIT;
                end
            end
            default: state_n = EMIT;
        endcase

        // Pad with 1s to the byte boundary, or assemble the strobed fields.
        if (state == FLUSH_PAD) begin
            add_len = (bit_count[2:0] == 3'd0) ? '0 : CNT_W'(4'd8 - {1'b0, bit_count[2:0]});
            sym     = field_bits(16'h00FF, add_len);
        end else if (accept_c) begin
            if (dc_armed) begin
                n       = clamp_len(jpeg_dc_out_length, 8'(DC_CODE_MAX));
                sym     = field_bits(16'(jpeg_dc_out), n);
                add_len = n;
                n       = clamp_len(jpeg_dc_code_size, 8'(AMP_MAX));
                sym     = (sym << n) | field_bits(16'(jpeg_dc_code_list), n);
                add_len = add_len + n;
            end
            n       = clamp_len(huffman_code_length, 8'(AC_CODE_MAX));
            sym     = (sym << n) | field_bits(huffman_code, n);
            add_len = add_len + n;
            n       = clamp_len(code_size_out, 8'(AMP_MAX));
            sym     = (sym << n) | field_bits(16'(code_out), n);
            add_len = add_len + n;
        end

        // Drain first, then place new bits right after what remains.
        acc_d       = drain_c ? (acc << 8) : acc;
        bc_d        = drain_c ? (bit_count - CNT_W'(8)) : bit_count;
        acc_n       = acc_d | (sym << (CNT_W'(ACC_W) - bc_d - add_len));
        bit_count_n = bc_d + add_len;

        in_ready_n = (bit_count_n <= CNT_W'(IN_READY_MAX)) && (state_n == EMIT);
`ifdef JPEG_BYTE_STUFF_EN
        if ((bit_count_n <= CNT_W'(IN_READY_MAX)) && (state_n == STUFF)) in_ready_n = 1'b1;
`endif
    end

    // Accumulator, DC prefix arming and status outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc          <= '0;
            bit_count    <= '0;
            dc_armed     <= 1'b1;
            in_ready     <= 1'b1;
            block_done   <= 1'b0;
            flush_done   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            acc        <= acc_n;
            bit_count  <= bit_count_n;
            in_ready   <= in_ready_n;
            block_done <= accept_c && jpeg_out_end;
            flush_done <= flush_done_n;
            if (accept_c) dc_armed <= jpeg_out_end;
            if (jpeg_out_enable && !in_ready) overflow_err <= 1'b1;
        end
    end

endmodule

// File: doc/jpeg_bit_packer.md
JPEG_BIT_PACKER -- requirements
Module: jpeg_bit_packer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are listed clock and reset first.
REQ-002 The ports SHALL be exactly these (name  direction  width  meaning):
  clock  in  1  rising-edge clock.
  reset_n  in  1  synchronous active-low reset.
  jpeg_out_enable  in  1  one-cycle symbol strobe from the Huffman controller.
  jpeg_out_end  in  1  marks the strobed symbol as the last one of the block.
  jpeg_dc_out  in  9  DC Huffman code, right-aligned.
  jpeg_dc_out_length  in  8  DC code length.
  jpeg_dc_code_list  in  8  DC amplitude bits, right-aligned.
  jpeg_dc_code_size  in  8  DC amplitude size.
  huffman_code  in  16  AC Huffman code, right-aligned.
  huffman_code_length  in  8  AC code length.
  code_out  in  8  AC amplitude bits, right-aligned.
  code_size_out  in  8  AC amplitude size.
  flush  in  1  end-of-image pad request.
  in_ready  out  1  high when a 41-bit worst-case append fits.
  byte_out  out  8  packed entropy byte.
  byte_valid  out  1  byte_out is valid.
  byte_ready  in  1  downstream accepts byte_out.
  block_done  out  1  one-cycle pulse after the last symbol of a block is appended.
  flush_done  out  1  one-cycle pulse when the flush has fully drained.
  overflow_err  out  1  sticky flag: a strobe was dropped.

Function
REQ-003 Bits SHALL be held in a 64-bit accumulator with a 7-bit bit_count; emission SHALL be MSB-first.
REQ-004 Appending a field SHALL take its N least-significant bits, with N clamped to 9 (DC code), 16 (AC code) or 8 (both amplitudes); N=0 SHALL append nothing.
REQ-005 On the first accepted strobe of a block, the append order SHALL be DC code, DC amplitude, AC code, AC amplitude; on later strobes it SHALL be AC code, AC amplitude.
REQ-006 All fields of one strobe SHALL be appended in the same cycle.
REQ-007 A strobe SHALL be accepted only when in_ready=1; in_ready SHALL be 1 when bit_count<=23 and no flush is active.
REQ-008 A strobe received while in_ready=0 SHALL be dropped and SHALL set overflow_err.
REQ-009 A strobe with jpeg_out_end=1 SHALL pulse block_done on the next cycle and SHALL rearm the DC prefix for the next block.
REQ-010 Output FSM states SHALL be EMIT, STUFF, FLUSH_PAD and FLUSH_DRAIN.
  - EMIT: when bit_count>=8 and the output register is empty or being consumed, the top 8 bits SHALL load into byte_out and byte_valid SHALL be set.
REQ-011 byte_out and byte_valid SHALL hold stable while byte_valid=1 and byte_ready=0.
REQ-012 A same-cycle append and byte drain SHALL both take effect, with the appended bits placed after the remaining bits.
REQ-013 flush SHALL be accepted only in EMIT with no strobe that cycle.
  - FLUSH_PAD SHALL pad with 1s up to the next byte boundary; no padding SHALL be added if bit_count%8==0.
  - FLUSH_DRAIN SHALL empty the accumulator and then pulse flush_done.
REQ-014 A byte is visible on byte_out at the earliest one cycle after the append that completes it.

Reset
REQ-015 While reset_n=0 at a rising clock edge, the block SHALL clear the accumulator, bit_count, FSM (to EMIT), DC prefix armed=1, byte_out=0, byte_valid=0, block_done=0, flush_done=0 and overflow_err=0.
REQ-016 in_ready SHALL read 1 on the first cycle after reset.
REQ-017 A reset during any state SHALL discard all buffered bits and any pending stuff byte.

Configuration
REQ-018 With JPEG_BYTE_STUFF_EN defined, every emitted 0xFF SHALL be followed by 0x00 via the STUFF state, during which no accumulator byte is emitted.
REQ-019 Without JPEG_BYTE_STUFF_EN, the STUFF state SHALL be absent and 0xFF SHALL be emitted unmodified.

Structure
REQ-020 Package jpeg_pkg SHALL hold ACC_W=64, MAX_SYM_BITS=41, the field clamp limits and the output FSM state encoding.
REQ-021 Byte stuffing and output registration SHALL live in sub-module jpeg_byte_stuffer, which has a valid/ready interface on both sides.

Verification
REQ-022 The bench SHALL cover at least these directed scenarios:
  - Strobe with DC 3'b010/len 3, amp 3'b101/size 3, AC 4'b1010/len 4, size 0, end=1, then flush -> bytes 0x56, 0xBF; block_done once; flush_done once.
  - AC 16'hFFFF/len 16 with JPEG_BYTE_STUFF_EN -> FF 00 FF 00; without it -> FF FF.
  - byte_ready=0 with 24 bits buffered -> in_ready=0; a strobe -> overflow_err=1, byte stream unchanged.
  - Lengths 0xFF on all fields -> clamped to 9+8+16+8=41 bits appended.
  - reset_n low one cycle with 20 bits buffered -> byte_valid=0, no further bytes, in_ready=1.
  - Flush with bit_count=16 -> exactly 2 bytes, no pad, then flush_done.
